fcmp_pipe: RTL
==============

FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 in_valid  input  1  operand beat offered.
REQ-004 in_ready  output  1  block accepts beat this cycle; transfer when in_valid && in_ready.
REQ-005 x1  input  32  IEEE-754 single operand A.
REQ-006 x2  input  32  IEEE-754 single operand B.
REQ-007 op  input  3  000 fle, 001 flt, 010 feq, 011 fmin, 100 fmax; 101-111 reserved.
REQ-008 out_valid  output  1  result beat held on y/exception.
REQ-009 out_ready  input  1  consumer accepts; transfer when out_valid && out_ready.
REQ-010 y  output  32  compare ops: {31'b0, flag}; fmin/fmax: selected 32-bit operand.
REQ-011 exception  output  1  per-beat flag: NaN operand or reserved op.
REQ-012 exc_sticky  output  1  OR of all exception beats transferred out since reset or clear.
REQ-013 exc_clr  input  1  synchronous clear of exc_sticky.

Function
REQ-014 Two-stage registered pipeline (S1 classify, S2 select/output); latency from input transfer to out_valid exactly 2 cycles when out_ready held high.
REQ-015 Throughput one beat per cycle with out_ready high; no bubbles inserted.
REQ-016 in_ready = !(S1 valid && S2 valid && !out_ready), combinational; 0 while rst high.
REQ-017 Backpressure: S2 holds y/exception/out_valid stable while out_valid && !out_ready; S1 advances into S2 only when S2 empty or transferring.
REQ-018 No beat dropped or duplicated under any in_valid/out_ready pattern.
REQ-019 NaN: exponent 8'hFF with mantissa != 0; infinities (mantissa 0) compare as ordered values.
REQ-020 Zero: bits[30:0] == 0; +0 and -0 compare equal for fle/flt/feq.
REQ-021 Ordering: same sign positive -> larger bits[30:0] is larger; both negative -> reversed; differing signs (not both zero) -> negative smaller; subnormals ordered by bit pattern.
REQ-022 fle/flt/feq with any NaN operand: flag 0, exception 1.
REQ-023 fmin/fmax: one NaN -> return other operand, exception 1; both NaN -> y = 32'h7FC00000, exception 1.
REQ-024 fmin(+0,-0) and fmin(-0,+0) = 32'h80000000; fmax of same pairs = 32'h00000000.
REQ-025 Equal non-zero operands for fmin/fmax: return x1.
REQ-026 Reserved op: y = 0, exception 1.
REQ-027 exc_sticky sets on the cycle after an output transfer with exception 1; exc_clr in same cycle as set wins set (sticky stays 1).
REQ-028 op, x1, x2 sampled only on input transfer; values with in_valid low ignored.

Reset
REQ-029 During/after rst: S1/S2 valid 0, out_valid 0, y 32'h0, exception 0, exc_sticky 0.
REQ-030 rst asserted mid-operation discards all in-flight beats; first cycle after release in_ready = 1.

Verification
REQ-031 op=fle, x1=3F800000 (1.0), x2=40000000 (2.0), out_ready=1 -> y=1, exception=0, out_valid exactly 2 cycles after transfer.
REQ-032 op=feq, x1=80000000, x2=00000000 -> y=1; op=flt same pair -> y=0; op=fmin -> y=80000000.
REQ-033 op=fle, x1=7FC00000, x2=3F800000 -> y=0, exception=1, exc_sticky=1 next cycle; exc_clr pulse -> exc_sticky=0.
REQ-034 op=fmax, x1=FF800000 (-inf), x2=7F7FFFFF -> y=7F7FFFFF; both NaN -> y=7FC00000, exception=1.
REQ-035 Stream 8 beats back-to-back with out_ready low 3 cycles mid-stream -> in_ready drops once pipe full; all 8 results emitted in order, none lost, y stable while stalled.
REQ-036 Random stream across all exponents incl. 0/255, both signs, edge mantissas (0, 1, all-ones, random) and random out_ready; compare against software float model; rst pulse mid-stream -> out_valid=0 immediately, no stale beat after release.

Source files
------------

// File: rtl/fcmp_pipe.sv
// fcmp_pipe: two-stage IEEE-754 single-precision compare / min / max pipeline.
// Stage 1 registers the operands together with their classification (NaN, zero,
// ordering); stage 2 registers the selected result and the per-beat exception.
//
// Handshake: a beat moves on the input side when in_valid && in_ready and on
// the output side when out_valid && out_ready. out_valid, y and exception hold
// steady while out_valid && !out_ready; stage 1 advances only into an empty or
// draining stage 2, and in_ready is low only when both stages are full and the
// consumer is stalling (and throughout reset).
module fcmp_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    input  logic [2:0]  op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        exception,
    output logic        exc_sticky,
    input  logic        exc_clr
);

    localparam logic [2:0] OP_FLE  = 3'b000;
    localparam logic [2:0] OP_FLT  = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FMIN = 3'b011;
    localparam logic [2:0] OP_FMAX = 3'b100;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Stage 1 registers
    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_op_q, s1_op_d;
    logic [31:0] s1_a_q, s1_a_d;
    logic [31:0] s1_b_q, s1_b_d;
    logic        s1_a_nan_q, s1_a_nan_d;
    logic        s1_b_nan_q, s1_b_nan_d;
    logic        s1_lt_q, s1_lt_d;
    logic        s1_eq_q, s1_eq_d;
    logic        s1_zz_q, s1_zz_d;

    // Stage 2 registers
    logic        s2_valid_q, s2_valid_d;
    logic [31:0] y_q, y_d;
    logic        exc_q, exc_d;
    logic        sticky_q, sticky_d;

    // Handshake and classification nets
    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;
    logic        out_fire;
    logic        a_nan, b_nan, both_zero, mag_lt, mag_eq, ord_lt, ord_eq;
    logic [31:0] res_y;
    logic        res_exc;

    // Flow control: stage 2 can take a beat when empty or when its beat leaves
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !rst && (!s1_valid_q || s2_free);
        in_fire  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;
    end

    // Classify the incoming operands: NaN detection and total ordering
    always_comb begin
        a_nan     = (x1[30:23] == 8'hFF) && (x1[22:0] != 23'd0);
        b_nan     = (x2[30:23] == 8'hFF) && (x2[22:0] != 23'd0);
        both_zero = (x1[30:0] == 31'd0) && (x2[30:0] == 31'd0);
        mag_lt    = x1[30:0] < x2[30:0];
        mag_eq    = x1[30:0] == x2[30:0];
        ord_eq    = both_zero || (x1 == x2);
        ord_lt    = 1'b0;
        if (both_zero) begin
            ord_lt = 1'b0;
        end else if (x1[31] != x2[31]) begin
            // differing signs: the negative operand is the smaller one
            ord_lt = x1[31];
        end else if (!x1[31]) begin
            ord_lt = mag_lt;
        end else begin
            // both negative: larger magnitude is the smaller value
            ord_lt = !mag_lt && !mag_eq;
        end
    end

    // Stage 1 next state: load on input transfer, empty when handed to stage 2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_a_nan_d = s1_a_nan_q;
        s1_b_nan_d = s1_b_nan_q;
        s1_lt_d    = s1_lt_q;
        s1_eq_d    = s1_eq_q;
        s1_zz_d    = s1_zz_q;
        if (in_fire) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op;
            s1_a_d     = x1;
            s1_b_d     = x2;
            s1_a_nan_d = a_nan;
            s1_b_nan_d = b_nan;
            s1_lt_d    = ord_lt;
            s1_eq_d    = ord_eq;
            s1_zz_d    = both_zero;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // Result selection from the stage 1 classification
    always_comb begin
        res_y   = 32'd0;
        res_exc = s1_a_nan_q || s1_b_nan_q;
        case (s1_op_q)
            OP_FLE: res_y = {31'd0, !res_exc && (s1_lt_q || s1_eq_q)};
            OP_FLT: res_y = {31'd0, !res_exc && s1_lt_q};
            OP_FEQ: res_y = {31'd0, !res_exc && s1_eq_q};
            OP_FMIN, OP_FMAX: begin
                if (s1_a_nan_q && s1_b_nan_q) begin
                    res_y = CANON_NAN;
                end else if (s1_a_nan_q) begin
                    res_y = s1_b_q;
                end else if (s1_b_nan_q) begin
                    res_y = s1_a_q;
                end else if (s1_zz_q) begin
                    // signed zeros: -0 is the minimum, +0 the maximum
                    if (s1_op_q == OP_FMIN) begin
                        res_y = {s1_a_q[31] | s1_b_q[31], 31'd0};
                    end else begin
                        res_y = {s1_a_q[31] & s1_b_q[31], 31'd0};
                    end
                end else if (s1_eq_q) begin
                    res_y = s1_a_q;
                end else if (s1_op_q == OP_FMIN) begin
                    res_y = s1_lt_q ? s1_a_q : s1_b_q;
                end else begin
                    res_y = s1_lt_q ? s1_b_q : s1_a_q;
                end
            end
            default: begin
                res_y   = 32'd0;
                res_exc = 1'b1;
            end
        endcase
    end

    // Stage 2 next state: capture on advance, hold while stalled
    always_comb begin
        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        exc_d      = exc_q;
        if (s1_adv) begin
            s2_valid_d = 1'b1;
            y_d        = res_y;
            exc_d      = res_exc;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    // Sticky exception: a transferred exception beat beats a same-cycle clear
    always_comb begin
        sticky_d = sticky_q;
        if (out_fire && exc_q) begin
            sticky_d = 1'b1;
        end else if (exc_clr) begin
            sticky_d = 1'b0;
        end
    end

    // Pipeline state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= 3'd0;
            s1_a_q     <= 32'd0;
            s1_b_q     <= 32'd0;
            s1_a_nan_q <= 1'b0;
            s1_b_nan_q <= 1'b0;
            s1_lt_q    <= 1'b0;
            s1_eq_q    <= 1'b0;
            s1_zz_q    <= 1'b0;
            s2_valid_q <= 1'b0;
            y_q        <= 32'd0;
            exc_q      <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_a_nan_q <= s1_a_nan_d;
            s1_b_nan_q <= s1_b_nan_d;
            s1_lt_q    <= s1_lt_d;
            s1_eq_q    <= s1_eq_d;
            s1_zz_q    <= s1_zz_d;
            s2_valid_q <= s2_valid_d;
            y_q        <= y_d;
            exc_q      <= exc_d;
            sticky_q   <= sticky_d;
        end
    end

    // Output drive
    always_comb begin
        out_valid  = s2_valid_q;
        y          = y_q;
        exception  = exc_q;
        exc_sticky = sticky_q;
    end

endmodule
